// File: rtl/fb_write_ctrl_pkg.sv
// Screen geometry, framebuffer constants and pixel record shared by the
// snake renderer, framebuffer writer and VGA scan-out.
package fb_write_ctrl_pkg;
  localparam int XSCREEN    = 160;
  localparam int YSCREEN    = 120;
  localparam int COLOR_W    = 9;
  localparam int ADDR_W     = 15;
  localparam int FIFO_DEPTH = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int FB_WORDS   = XSCREEN * YSCREEN;
  localparam logic [COLOR_W-1:0] BG_COLOR = 9'b000_000_000;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} fb_state_e;

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] color;
  } pix_t;

  // y*160 + x as shift-adds: 160 = 128 + 32
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [ADDR_W-1:0] yw;
    yw = {8'd0, y};
    pix_addr = (yw << 7) + (yw << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/fb_write_ctrl_pix_fifo.sv
// Synchronous pixel FIFO; caller guarantees no push when full without a
// pop and no pop when empty.
module pix_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 24
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: pointers define which entries are live.
  always_ff @(posedge Clock) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
endmodule

// File: rtl/fb_write_ctrl.sv
// Framebuffer write port owner: clear sweep after reset / on request, then
// drains buffered pixel writes into linear framebuffer addresses.
module fb_write_ctrl
  import fb_write_ctrl_pkg::*;
(
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [7:0]         pix_x,
  input  logic [6:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               pix_write,
  input  logic               clear_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  output logic               busy,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic               oob
);
  fb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  cnt_q, cnt_d, sweep_addr;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] data_q, data_d;
  logic               we_q, we_d, ovf_q, ovf_d, oob_q, oob_d;
  logic               in_range, push, pop, full, empty;
  pix_t               head, wr_pix;

  assign in_range = (pix_x < 8'(XSCREEN)) && (pix_y < 7'(YSCREEN));
  assign pop      = (state_q == ST_RUN) && !clear_req && !empty;
  assign push     = pix_write && in_range && (!full || pop);
  assign wr_pix   = '{x: pix_x, y: pix_y, color: pix_color};

  pix_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(pix_t))) u_fifo (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_pix),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ovf_q   <= 1'b0;
      oob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      ovf_q   <= ovf_d;
      oob_q   <= oob_d;
    end
  end

  // A request during the sweep restarts it in place, so mem_we never drops.
  assign sweep_addr = clear_req ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = sweep_addr + 1'b1;
        if (sweep_addr == ADDR_W'(FB_WORDS - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (state_q == ST_CLEAR) begin
      we_d   = 1'b1;
      addr_d = sweep_addr;
      data_d = BG_COLOR;
    end else if (pop) begin
      we_d   = 1'b1;
      addr_d = pix_addr(head.x, head.y);
      data_d = head.color;
    end
    ovf_d = ovf_q | (pix_write & in_range & full & ~pop);
    oob_d = oob_q | (pix_write & ~in_range);
  end

  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign mem_we   = we_q;
  assign busy     = (state_q == ST_CLEAR);
  assign overflow = ovf_q;
  assign oob      = oob_q;
endmodule

// File: doc/fb_write_ctrl.md
Name: fb_write_ctrl

Overview:
Sits directly downstream of the snake drawing FSM. It accepts its per-pixel write stream (x, y, 9-bit color, write strobe) on the 160x120 grid and buffers it in a small FIFO. It converts coordinates to linear framebuffer addresses and drives the single write port of the 19200x9 video memory that the VGA scan-out reads. It also owns the clear-screen sweep, which runs after reset and on request.

Parameters:
XSCREEN, 160, grid width in pixels
YSCREEN, 120, grid height in pixels
FIFO_DEPTH, 16, pixel write FIFO entries (power of two)
BG_COLOR, 9'b000_000_000, color written by clear sweep
ADDR_W, 15, framebuffer address width (ceil log2 of 19200)

Ports:
Clock  in  1  system clock (50 MHz)
Resetn  in  1  asynchronous active-low reset
pix_x  in  8  pixel column
pix_y  in  7  pixel row
pix_color  in  9  RGB 3:3:3 color
pix_write  in  1  write strobe; one pixel per high cycle
clear_req  in  1  single-cycle pulse: restart clear sweep
mem_addr  out  ADDR_W  framebuffer write address
mem_data  out  9  framebuffer write data
mem_we  out  1  framebuffer write enable
busy  out  1  high while clear sweep active
fifo_level  out  5  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: a valid pixel was dropped because the FIFO was full
oob  out  1  sticky: a pixel with x>=XSCREEN or y>=YSCREEN was dropped

Behaviour:
- One clock; reset is asynchronous and active-low: Clock, Resetn. All state and outputs are reset by Resetn low.
- Reset values: mem_addr=0, mem_data=0, mem_we=0, busy=1, fifo_level=0, overflow=0, oob=0. State=CLEAR, sweep counter=0.
- States: CLEAR, RUN.
- CLEAR state:
  - Each cycle drive mem_we=1, mem_addr=counter, mem_data=BG_COLOR, then increment the counter.
  - After address 19199 is written, go to RUN and set busy=0. The sweep therefore takes exactly 19200 cycles with mem_we high.
- RUN state:
  - If the FIFO is non-empty, pop one entry per cycle and register mem_addr = y*XSCREEN + x, mem_data = color, mem_we=1.
  - Otherwise mem_we=0.
  - Compute the address as (y<<7)+(y<<5)+x in ADDR_W bits; no multiplier.
- Input acceptance (both states):
  - A pixel is pushed on any edge where pix_write=1, x<XSCREEN and y<YSCREEN, and the FIFO has room.
  - Pixels arriving during CLEAR are buffered, not dropped. They are drained after the sweep, so they are never overwritten by it.
- Latency: a pixel pushed at edge N into an empty FIFO in RUN appears with mem_we=1 in the cycle after edge N+1 (2 cycles).
- Full FIFO:
  - A simultaneous push and pop is accepted.
  - A push while full with no pop drops the pixel, sets overflow=1, and leaves fifo_level at FIFO_DEPTH.
- Out of range: the pixel is dropped, oob=1, and the FIFO is unchanged. The oob check takes precedence over the full check, and overflow is not set.
- clear_req:
  - In RUN: go to CLEAR, counter=0, busy=1. FIFO contents are retained.
  - In CLEAR: restart the counter at 0.
  - A clear_req in the same cycle as the final sweep write restarts the sweep.
- Sticky flags: overflow and oob clear only on reset.
- fifo_level updates in the same edge as push/pop (push only +1, pop only -1, both = unchanged).
- Reset mid-sweep or mid-drain: immediate return to reset values. FIFO contents are discarded and the sweep restarts from 0.

Decomposition:
- Shared package: XSCREEN/YSCREEN, color width (9), ADDR_W, BG_COLOR, and the state encoding CLEAR/RUN. The snake block and VGA scan-out reuse the screen constants.
- One sub-module: pix_fifo. It is a synchronous FIFO of 24-bit {x,y,color} entries with push, pop, full, empty and level outputs, using the same Clock/Resetn.

Test Plan:
- Release reset -> mem_we=1 for exactly 19200 consecutive cycles, addresses 0..19199, data 0, then busy=0 and mem_we=0.
- After the sweep, write x=5, y=3, color=9'h1FF -> two cycles later mem_addr=485, mem_data=9'h1FF, mem_we=1 for one cycle.
- 20 back-to-back writes during CLEAR -> first 16 retained and written in order after the sweep; overflow=1; the last 4 are never seen on the memory port.
- Write x=160, y=0 and x=0, y=120 -> no memory write, oob=1, fifo_level stays 0, overflow=0.
- Pulse clear_req with 3 entries queued in RUN -> busy=1, sweep restarts at address 0; the 3 entries are written after address 19199.
- Deassert Resetn mid-sweep at address 1000 -> outputs immediately at reset values; after release, the sweep restarts at address 0.
